// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fb_writer
// Description : Clips, de-duplicates and buffers a pixel stream into
//               framebuffer write requests with a per-frame handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fb_writer #(
    parameter int H_RES      = 256,
    parameter int V_RES      = 128,
    parameter int ADDR_W     = 15,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [8:0]         pix_x,
    input  logic [7:0]         pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               stream_done,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    input  logic               fb_ack,
    output logic               frame_done,
    output logic [15:0]        clip_count
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = ADDR_W + COLOR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W:0]       r_count;
    logic [15:0]            r_clip_count;
    logic [ADDR_W-1:0]      r_last_addr;
    logic                   r_last_valid;

    logic signed [31:0]     w_x_s;
    logic signed [31:0]     w_y_s;
    logic                   w_in_range;
    logic [ADDR_W-1:0]      w_addr;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_dup;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_clip;
    logic                   w_start_take;
    logic [c_ENTRY_W-1:0]   w_head;

    // Coordinates are two's complement; sign-extend before range checks.
    assign w_x_s      = {{23{pix_x[8]}}, pix_x};
    assign w_y_s      = {{24{pix_y[7]}}, pix_y};
    assign w_in_range = (w_x_s >= 0) && (w_x_s < H_RES) &&
                        (w_y_s >= 0) && (w_y_s < V_RES);
    assign w_addr     = ADDR_W'(w_y_s * H_RES + w_x_s);

    assign w_full       = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign pix_ready    = (r_state == RUN) && !w_full;
    assign w_accept     = pix_valid && pix_ready;
    assign w_dup        = r_last_valid && (w_addr == r_last_addr);
    assign w_push       = w_accept && w_in_range && !w_dup;
    assign w_clip       = w_accept && !w_in_range;
    assign w_pop        = !w_empty && fb_ack;
    assign w_start_take = start && ((r_state == IDLE) || (r_state == DONE));

    // Head is masked while empty so stale storage never reaches the bus.
    assign w_head     = r_mem[r_rd_ptr];
    assign fb_we      = !w_empty;
    assign fb_addr    = w_empty ? '0 : w_head[c_ENTRY_W-1:COLOR_W];
    assign fb_wdata   = w_empty ? '0 : w_head[COLOR_W-1:0];
    assign frame_done = (r_state == DONE);
    assign clip_count = r_clip_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_addr, pix_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_clip_count <= '0;
            r_last_addr  <= '0;
            r_last_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (start)       r_state <= RUN;
                RUN:     if (stream_done) r_state <= DRAIN;
                DRAIN:   if (w_empty)     r_state <= DONE;
                DONE:    if (start)       r_state <= RUN;
                default:                  r_state <= IDLE;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_start_take) begin
                r_clip_count <= '0;
            end else if (w_clip && (r_clip_count != 16'hFFFF)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end

            if (w_start_take) begin
                r_last_valid <= 1'b0;
            end else if (w_push) begin
                r_last_valid <= 1'b1;
                r_last_addr  <= w_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter H_RES, 256, framebuffer width in pixels; valid x range 0..H_RES-1.
REQ-002 SHALL have parameter V_RES, 128, framebuffer height in pixels; valid y range 0..V_RES-1.
REQ-003 SHALL have parameter ADDR_W, 15, framebuffer address width; ceil(log2(H_RES*V_RES)) or more.
REQ-004 SHALL have parameter COLOR_W, 8, pixel colour width.
REQ-005 SHALL have parameter FIFO_DEPTH, 4, write-buffer entries; power of two, at least 2.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  single-cycle pulse that arms a new frame.
REQ-009 pix_valid  in  1  producer presents a pixel.
REQ-010 pix_ready  out  1  block can accept a pixel this cycle.
REQ-011 pix_x  in  9  signed pixel x coordinate.
REQ-012 pix_y  in  8  signed pixel y coordinate.
REQ-013 pix_color  in  COLOR_W  pixel colour.
REQ-014 stream_done  in  1  producer has finished the figure; level or pulse.
REQ-015 fb_we  out  1  framebuffer write request.
REQ-016 fb_addr  out  ADDR_W  framebuffer word address = y*H_RES + x.
REQ-017 fb_wdata  out  COLOR_W  write data.
REQ-018 fb_ack  in  1  framebuffer accepts the current write.
REQ-019 frame_done  out  1  level; all accepted pixels have been written.
REQ-020 clip_count  out  16  number of off-screen pixels dropped this frame.

Function
REQ-021 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-022 The FSM SHALL make these transitions: IDLE -start-> RUN; RUN -stream_done-> DRAIN; DRAIN -FIFO empty-> DONE; DONE -start-> RUN.
REQ-023 start in RUN or DRAIN SHALL be ignored; stream_done outside RUN SHALL be ignored.
REQ-024 pix_ready SHALL equal (state==RUN) AND FIFO not full; a full FIFO deasserts pix_ready even in a cycle that pops.
REQ-025 Accept occurs when pix_valid AND pix_ready; in-range test: 0<=pix_x<H_RES and 0<=pix_y<V_RES, using signed compare.
REQ-026 An in-range accepted pixel SHALL be pushed into the FIFO as {addr, color} with addr=pix_y*H_RES+pix_x, truncated to ADDR_W bits.
REQ-027 An out-of-range pixel SHALL be accepted and dropped, and clip_count SHALL increment, saturating at 16'hFFFF.
REQ-028 Duplicate suppression: an in-range pixel whose addr equals the last pushed addr of this frame SHALL be accepted and dropped, with no count change.
REQ-029 The last-pushed-addr valid flag SHALL clear on start.
REQ-030 fb_we SHALL equal FIFO not empty; fb_addr and fb_wdata SHALL equal the FIFO head.
REQ-031 The FIFO head SHALL pop on fb_we AND fb_ack.
REQ-032 The head SHALL be held stable while fb_we=1 and fb_ack=0.
REQ-033 Latency: an in-range pixel accepted on edge N SHALL appear on fb_we/fb_addr after edge N when the FIFO is empty, i.e. one cycle.
REQ-034 Writes SHALL emerge in acceptance order, with none lost or repeated.
REQ-035 When stream_done and an accept coincide in RUN, the pixel SHALL be accepted and the state SHALL become DRAIN.
REQ-036 When the FIFO is empty on entry to DRAIN, DONE SHALL follow on the next edge.
REQ-037 frame_done SHALL be 1 only in DONE; it clears on the edge that takes start.
REQ-038 start SHALL clear clip_count to 0.
REQ-039 Simultaneous push and pop with a non-full FIFO SHALL keep the occupancy unchanged.
REQ-040 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-041 On reset assertion, immediately and asynchronously: state IDLE, FIFO empty, pointers 0, fb_we=0, pix_ready=0, frame_done=0, clip_count=0, last-addr flag cleared.
REQ-042 fb_addr and fb_wdata SHALL be 0 during reset.
REQ-043 Reset mid-frame SHALL discard all buffered writes; no write occurs after reset deasserts until start and a new accept.

Verification
REQ-044 Reset, start, pixel (3,2,color 8'h5A) with fb_ack=1 -> one cycle later fb_we=1, fb_addr=515, fb_wdata=8'h5A, for exactly one cycle.
REQ-045 Pixels (-1,0), (256,5) and (10,-3) -> no fb_we, clip_count=3; then (255,127) -> fb_addr=32767.
REQ-046 fb_ack=0, push 4 pixels -> pix_ready=0 after the 4th; release fb_ack -> four writes in order, then pix_ready=1.
REQ-047 Same pixel (7,7) twice, then (8,7) -> exactly two writes, fb_addr 1799 then 1800.
REQ-048 stream_done with 2 entries buffered, fb_ack=1 -> two writes, then frame_done=1; start -> frame_done=0 and clip_count=0.
REQ-049 Reset with 3 entries buffered -> fb_we=0 immediately, state IDLE; after release, no writes until start.
